// File: rtl/cke_sched_pkg.sv
// Shared types and constants for the emulated-time clock-enable scheduler.
`timescale 1ns/1ps
package cke_sched_pkg;

    localparam int TIME_W_DEF = 32;

    typedef logic [TIME_W_DEF-1:0] time_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Smallest legal RX period: keeps the half-period rx_n delta nonzero.
    localparam int RX_PERIOD_MIN = 2;

    // Delta value that parks a disabled domain out of the min search.
    localparam time_t TIME_INF = '1;

endpackage

// File: rtl/cke_min3.sv
// Combinational 3-way unsigned minimum with per-input "equals the minimum" flags.
`timescale 1ns/1ps
module cke_min3 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] min_v,
    output logic         eq_a,
    output logic         eq_b,
    output logic         eq_c
);

    logic [W-1:0] min_ab;

    always_comb begin
        min_ab = (a < b) ? a : b;
        min_v  = (min_ab < c) ? min_ab : c;
        eq_a   = (a == min_v);
        eq_b   = (b == min_v);
        eq_c   = (c == min_v);
    end

endmodule

// File: rtl/cke_scheduler.sv
// Emulated-time scheduler: each clk_sys step jumps to the nearest TX/RX edge and pulses its enables.
// Optional event counters are built when CKE_STATS_EN is defined.
`timescale 1ns/1ps
module cke_scheduler
    import cke_sched_pkg::*;
#(
    parameter int          TIME_W   = 32,
    parameter int unsigned TX_PHASE = 0,
    parameter int unsigned RX_PHASE = 0,
    parameter int          CNT_W    = 32
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              run,
    input  logic [TIME_W-1:0] tx_period,
    input  logic [TIME_W-1:0] rx_period,
    input  logic              rx_period_vld,
    output logic              cke_tx,
    output logic              cke_rx_p,
    output logic              cke_rx_n,
    output logic [TIME_W-1:0] time_now,
    output logic [1:0]        state_dbg
`ifdef CKE_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt_tx,
    output logic [CNT_W-1:0]  cnt_rx_p,
    output logic [CNT_W-1:0]  cnt_rx_n
`endif
);

    localparam logic [TIME_W-1:0] D_OFF =
        (TIME_W <= TIME_W_DEF) ? TIME_W'(TIME_INF) : {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0] RX_MIN = TIME_W'(RX_PERIOD_MIN);

    state_e            state;
    logic [TIME_W-1:0] d_tx;
    logic [TIME_W-1:0] d_rxp;
    logic [TIME_W-1:0] d_rxn;
    logic [TIME_W-1:0] rx_cur;
    logic [TIME_W-1:0] rx_pend;
    logic              tx_armed;

    logic              tx_en;
    logic [TIME_W-1:0] d_tx_eff;
    logic [TIME_W-1:0] dmin;
    logic              eq_tx;
    logic              fire_tx;
    logic              fire_rxp;
    logic              fire_rxn;
    logic [TIME_W-1:0] rx_clamped;

    assign state_dbg = state;

    // TX only competes for the minimum once a nonzero period has armed it.
    assign tx_en      = (tx_period != '0) && tx_armed;
    assign d_tx_eff   = tx_en ? d_tx : D_OFF;
    assign fire_tx    = tx_en && eq_tx;
    assign rx_clamped = (rx_period < RX_MIN) ? RX_MIN : rx_period;

    cke_min3 #(.W(TIME_W)) u_min3 (
        .a     (d_tx_eff),
        .b     (d_rxp),
        .c     (d_rxn),
        .min_v (dmin),
        .eq_a  (eq_tx),
        .eq_b  (fire_rxp),
        .eq_c  (fire_rxn)
    );

    // rx_period_vld is a one-cycle strobe with no back-pressure: every cycle it is
    // high (outside reset) rx_period is clamped and overwrites the pending period.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= INIT;
            cke_tx   <= 1'b0;
            cke_rx_p <= 1'b0;
            cke_rx_n <= 1'b0;
            time_now <= '0;
            rx_cur   <= RX_MIN;
            rx_pend  <= RX_MIN;
            d_tx     <= '0;
            d_rxp    <= '0;
            d_rxn    <= '0;
            tx_armed <= 1'b0;
`ifdef CKE_STATS_EN
            cnt_tx   <= '0;
            cnt_rx_p <= '0;
            cnt_rx_n <= '0;
`endif
        end else begin
            cke_tx   <= 1'b0;
            cke_rx_p <= 1'b0;
            cke_rx_n <= 1'b0;
            if (rx_period_vld) begin
                rx_pend <= rx_clamped;
            end
            case (state)
                INIT: begin
                    d_tx     <= TIME_W'(TX_PHASE);
                    d_rxp    <= TIME_W'(RX_PHASE);
                    d_rxn    <= TIME_W'(RX_PHASE) + (rx_cur >> 1);
                    time_now <= '0;
                    tx_armed <= 1'b1;
                    state    <= run ? RUN : HOLD;
                end
                HOLD: begin
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= HOLD;
                    end else begin
                        cke_tx   <= fire_tx;
                        cke_rx_p <= fire_rxp;
                        cke_rx_n <= fire_rxn;
                        time_now <= time_now + dmin;

                        if (tx_period == '0) begin
                            tx_armed <= 1'b0;
                        end else if (!tx_armed) begin
                            d_tx     <= tx_period;
                            tx_armed <= 1'b1;
                        end else if (fire_tx) begin
                            d_tx <= tx_period;
                        end else begin
                            d_tx <= d_tx - dmin;
                        end

                        // An rx_p edge adopts the pending period and re-anchors rx_n half a period later.
                        if (fire_rxp) begin
                            rx_cur <= rx_pend;
                            d_rxp  <= rx_pend;
                            d_rxn  <= rx_pend >> 1;
                        end else begin
                            d_rxp <= d_rxp - dmin;
                            d_rxn <= fire_rxn ? rx_cur : (d_rxn - dmin);
                        end
`ifdef CKE_STATS_EN
                        cnt_tx   <= cnt_tx   + CNT_W'(fire_tx);
                        cnt_rx_p <= cnt_rx_p + CNT_W'(fire_rxp);
                        cnt_rx_n <= cnt_rx_n + CNT_W'(fire_rxn);
`endif
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cke_scheduler.sv
// Directed bench for cke_scheduler: step-by-step edge/time sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_cke_scheduler;
    import cke_sched_pkg::*;

    logic        clk_sys;
    logic        rst;
    logic        run;
    logic [31:0] tx_period;
    logic [31:0] rx_period;
    logic        rx_period_vld;
    logic        cke_tx;
    logic        cke_rx_p;
    logic        cke_rx_n;
    logic [31:0] time_now;
    logic [1:0]  state_dbg;
`ifdef CKE_STATS_EN
    logic [31:0] cnt_tx;
    logic [31:0] cnt_rx_p;
    logic [31:0] cnt_rx_n;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cke_scheduler #(
        .TIME_W   (32),
        .TX_PHASE (0),
        .RX_PHASE (0),
        .CNT_W    (32)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .run           (run),
        .tx_period     (tx_period),
        .rx_period     (rx_period),
        .rx_period_vld (rx_period_vld),
        .cke_tx        (cke_tx),
        .cke_rx_p      (cke_rx_p),
        .cke_rx_n      (cke_rx_n),
        .time_now      (time_now),
        .state_dbg     (state_dbg)
`ifdef CKE_STATS_EN
        ,
        .cnt_tx        (cnt_tx),
        .cnt_rx_p      (cnt_rx_p),
        .cnt_rx_n      (cnt_rx_n)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Wait for the next falling edge, then compare the step outputs.
    task automatic chk(input string tag, input logic etx, input logic erxp,
                       input logic erxn, input time_t et);
        @(negedge clk_sys);
        n_tests++;
        assert ({cke_tx, cke_rx_p, cke_rx_n, time_now} === {etx, erxp, erxn, et}) else begin
            n_fail++;
            $display("FAIL %s: observed tx=%0b rxp=%0b rxn=%0b t=%0d, expected tx=%0b rxp=%0b rxn=%0b t=%0d",
                     tag, cke_tx, cke_rx_p, cke_rx_n, time_now, etx, erxp, erxn, et);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_state(input string tag, input state_e es);
        n_tests++;
        assert (state_dbg === es) else begin
            n_fail++;
            $display("FAIL %s: observed state=%0d, expected state=%0d", tag, state_dbg, es);
            $error("check %s", tag);
        end
    endtask

    initial begin
        rst           = 1'b1;
        run           = 1'b0;
        tx_period     = 32'd10;
        rx_period     = 32'd10;
        rx_period_vld = 1'b0;

        // Reset state
        chk("reset_out", 1'b0, 1'b0, 1'b0, 0);
        chk("reset_out2", 1'b0, 1'b0, 1'b0, 0);
        chk_state("reset_state", INIT);

        // tx=10, rx=10, phases 0
        rst           = 1'b0;
        run           = 1'b1;
        rx_period_vld = 1'b1;
        chk("init_idle", 1'b0, 1'b0, 1'b0, 0);
        chk_state("init_to_run", RUN);
        rx_period_vld = 1'b0;
        chk("a_t0", 1'b1, 1'b1, 1'b0, 0);
        chk("a_t5", 1'b0, 1'b0, 1'b1, 5);
        chk("a_t10", 1'b1, 1'b1, 1'b0, 10);
        chk("a_t15", 1'b0, 1'b0, 1'b1, 15);
        chk("a_t20", 1'b1, 1'b1, 1'b0, 20);

        // run low for 4 cycles: outputs idle, time frozen
        run = 1'b0;
        chk("hold_0", 1'b0, 1'b0, 1'b0, 20);
        chk_state("hold_state", HOLD);
        chk("hold_1", 1'b0, 1'b0, 1'b0, 20);
        chk("hold_2", 1'b0, 1'b0, 1'b0, 20);
        chk("hold_3", 1'b0, 1'b0, 1'b0, 20);
        run = 1'b1;
        chk("resume_gap", 1'b0, 1'b0, 1'b0, 20);
        chk("resume_t25", 1'b0, 1'b0, 1'b1, 25);
        chk("resume_t30", 1'b1, 1'b1, 1'b0, 30);

        // RX period 10 -> 20 mid-period: pending rx_n unaffected, new period from next rx_p
        rx_period     = 32'd20;
        rx_period_vld = 1'b1;
        chk("rx20_t35", 1'b0, 1'b0, 1'b1, 35);
        rx_period_vld = 1'b0;
        chk("rx20_t40", 1'b1, 1'b1, 1'b0, 40);
        chk("rx20_t50", 1'b1, 1'b0, 1'b1, 50);
        chk("rx20_t60", 1'b1, 1'b1, 1'b0, 60);
        chk("rx20_t70", 1'b1, 1'b0, 1'b1, 70);

        // Reset mid-RUN with edges pending
        rst = 1'b1;
        chk("midrst_out", 1'b0, 1'b0, 1'b0, 0);
        chk_state("midrst_state", INIT);

        // tx=7, rx=10
        rst           = 1'b0;
        tx_period     = 32'd7;
        rx_period     = 32'd10;
        rx_period_vld = 1'b1;
        chk("b_init", 1'b0, 1'b0, 1'b0, 0);
        rx_period_vld = 1'b0;
        chk("b_t0", 1'b1, 1'b1, 1'b0, 0);
        chk("b_t5", 1'b0, 1'b0, 1'b1, 5);
        chk("b_t7", 1'b1, 1'b0, 1'b0, 7);
        chk("b_t10", 1'b0, 1'b1, 1'b0, 10);
        chk("b_t14", 1'b1, 1'b0, 1'b0, 14);
        chk("b_t15", 1'b0, 1'b0, 1'b1, 15);
        chk("b_t20", 1'b0, 1'b1, 1'b0, 20);
        chk("b_t21", 1'b1, 1'b0, 1'b0, 21);

        // TX disabled, rx_period=1 clamped to 2
        tx_period     = 32'd0;
        rx_period     = 32'd1;
        rx_period_vld = 1'b1;
        chk("c_t25", 1'b0, 1'b0, 1'b1, 25);
        rx_period_vld = 1'b0;
        chk("c_t30", 1'b0, 1'b1, 1'b0, 30);
        chk("c_t31", 1'b0, 1'b0, 1'b1, 31);
        chk("c_t32", 1'b0, 1'b1, 1'b0, 32);
        chk("c_t33", 1'b0, 1'b0, 1'b1, 33);
        chk("c_t34", 1'b0, 1'b1, 1'b0, 34);

        // Re-arm TX with period 3
        tx_period = 32'd3;
        chk("arm_t35", 1'b0, 1'b0, 1'b1, 35);
        chk("arm_t36", 1'b0, 1'b1, 1'b0, 36);
        chk("arm_t37", 1'b0, 1'b0, 1'b1, 37);
        chk("arm_t38", 1'b1, 1'b1, 1'b0, 38);

        // 100 steps at tx=rx=10
        rst = 1'b1;
        chk("d_reset", 1'b0, 1'b0, 1'b0, 0);
        rst           = 1'b0;
        tx_period     = 32'd10;
        rx_period     = 32'd10;
        rx_period_vld = 1'b1;
        @(negedge clk_sys);
        rx_period_vld = 1'b0;
        repeat (99) @(negedge clk_sys);
        chk("d_step100", 1'b0, 1'b0, 1'b1, 495);
`ifdef CKE_STATS_EN
        n_tests++;
        assert ({cnt_tx, cnt_rx_p, cnt_rx_n} === {32'd50, 32'd50, 32'd50}) else begin
            n_fail++;
            $display("FAIL stats_100: observed tx=%0d rxp=%0d rxn=%0d, expected 50 50 50",
                     cnt_tx, cnt_rx_p, cnt_rx_n);
            $error("check stats_100");
        end
        rst = 1'b1;
        @(negedge clk_sys);
        n_tests++;
        assert ({cnt_tx, cnt_rx_p, cnt_rx_n} === 96'd0) else begin
            n_fail++;
            $display("FAIL stats_clear: observed tx=%0d rxp=%0d rxn=%0d, expected 0 0 0",
                     cnt_tx, cnt_rx_p, cnt_rx_n);
            $error("check stats_clear");
        end
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
